// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite OAM DMA sequencer that stalls the CPU and copies one 256-byte page to $2004.
module oam_dma_ctrl #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] OAM_ADDR  = 16'h2004,
    parameter int          XFER_LEN  = 256
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_rw_n,
    input  logic [7:0]  bus_data_in,
    output logic        cpu_enable,
    output logic        dma_bus_req,
    output logic [15:0] dma_addr,
    output logic        dma_rw_n,
    output logic [7:0]  dma_data_out,
    output logic        dma_done
);
    typedef enum logic [2:0] {IDLE = 3'd0, HALT = 3'd1, ALIGN = 3'd2, READ = 3'd3, WRITE = 3'd4} state_t;
    state_t     state_q;
    logic       par_q;
    logic [7:0] page_q, idx_q, byte_q;
    logic       last_q;
    assign last_q = idx_q == 8'(XFER_LEN - 1);
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= IDLE;
            par_q   <= 1'b0;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            byte_q  <= 8'h00;
        end else begin
            par_q <= ~par_q;
            case (state_q)
                IDLE: if (!cpu_rw_n && cpu_addr == TRIG_ADDR) begin
                    page_q  <= cpu_data_out;
                    idx_q   <= 8'h00;
                    state_q <= HALT;
                end
                // reads must land on get (par=0) cycles, so an odd start burns one ALIGN cycle
                HALT:  state_q <= par_q ? READ : ALIGN;
                ALIGN: state_q <= READ;
                READ: begin
                    byte_q  <= bus_data_in;
                    state_q <= WRITE;
                end
                WRITE: begin
                    idx_q   <= last_q ? 8'h00 : idx_q + 8'h01;
                    state_q <= last_q ? IDLE : READ;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign cpu_enable   = state_q == IDLE;
    assign dma_bus_req  = state_q == READ || state_q == WRITE;
    assign dma_addr     = state_q == READ ? {page_q, idx_q} : state_q == WRITE ? OAM_ADDR : 16'h0000;
    assign dma_rw_n     = state_q != WRITE;
    assign dma_data_out = byte_q;
    assign dma_done     = state_q == WRITE && last_q;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: directed bench with a byte scoreboard filled at trigger and drained on OAM writes.
module tb_oam_dma_ctrl;
    logic        CLK = 1'b0;
    logic        RESET_n = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data_out = 8'h00;
    logic        cpu_rw_n = 1'b1;
    logic [7:0]  bus_data_in;
    logic        cpu_enable, dma_bus_req, dma_rw_n, dma_done;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_out;
    logic [7:0]  mem [0:65535];
    logic [7:0]  sb [$];
    logic        mpar;
    int          total = 0;
    int          bad = 0;
    logic [15:0] last_rd;

    oam_dma_ctrl dut (
        .CLK(CLK), .RESET_n(RESET_n), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
        .cpu_rw_n(cpu_rw_n), .bus_data_in(bus_data_in), .cpu_enable(cpu_enable),
        .dma_bus_req(dma_bus_req), .dma_addr(dma_addr), .dma_rw_n(dma_rw_n),
        .dma_data_out(dma_data_out), .dma_done(dma_done)
    );

    always #5 CLK = ~CLK;
    assign bus_data_in = mem[dma_addr];

    // reference cycle parity: 0 on the first cycle after reset, toggling every edge
    always @(posedge CLK or negedge RESET_n)
        if (!RESET_n) mpar <= 1'b0;
        else mpar <= ~mpar;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_en"}, 32'(cpu_enable), 32'd1);
        chk({tag, "_req"}, 32'(dma_bus_req), 32'd0);
        chk({tag, "_addr"}, 32'(dma_addr), 32'd0);
        chk({tag, "_rw"}, 32'(dma_rw_n), 32'd1);
        chk({tag, "_dout"}, 32'(dma_data_out), 32'd0);
        chk({tag, "_done"}, 32'(dma_done), 32'd0);
    endtask

    // hp = desired parity of the HALT cycle; abort_at >= 0 resets during that write index
    task automatic run_dma(input logic [7:0] pg, input logic hp, input int abort_at,
                           output logic [15:0] lrd);
        int low = 0, wr = 0, rd = 0;
        logic [7:0] e;
        lrd = 16'h0000;
        for (int i = 0; i < 256; i++) sb.push_back(mem[{pg, 8'(i)}]);
        if (mpar === hp) @(negedge CLK);
        cpu_addr = 16'h4014; cpu_data_out = pg; cpu_rw_n = 1'b0;
        @(negedge CLK);
        cpu_addr = 16'h0000; cpu_data_out = 8'h00; cpu_rw_n = 1'b1;
        chk("halt_en", 32'(cpu_enable), 32'd0);
        chk("halt_req", 32'(dma_bus_req), 32'd0);
        while (!cpu_enable && low < 600) begin
            low++;
            if (dma_bus_req && dma_rw_n) begin
                chk("rd_par", 32'(mpar), 32'd0);
                chk("rd_addr", 32'(dma_addr), 32'({pg, 8'(rd)}));
                lrd = dma_addr;
                rd++;
            end else if (dma_bus_req) begin
                if (wr == abort_at) begin
                    RESET_n = 1'b0;
                    #1;
                    chk_idle_outputs("abort");
                    sb.delete();
                    @(negedge CLK);
                    chk_idle_outputs("abort_hold");
                    RESET_n = 1'b1;
                    break;
                end
                e = sb.size() > 0 ? sb.pop_front() : 8'hxx;
                chk("wr_addr", 32'(dma_addr), 32'h2004);
                chk("wr_data", 32'(dma_data_out), 32'(e));
                chk("wr_done", 32'(dma_done), 32'(wr == 255));
                wr++;
            end else begin
                chk("stall_done", 32'(dma_done), 32'd0);
            end
            @(negedge CLK);
        end
        if (abort_at >= 0) begin
            chk("abort_idx", 32'(wr), 32'(abort_at));
        end else begin
            chk("low_cycles", 32'(low), hp ? 32'd513 : 32'd514);
            chk("wr_count", 32'(wr), 32'd256);
            chk("rd_count", 32'(rd), 32'd256);
            chk("sb_empty", 32'(sb.size()), 32'd0);
            chk("post_req", 32'(dma_bus_req), 32'd0);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
        for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'hA5;
        @(negedge CLK);
        @(negedge CLK);
        chk_idle_outputs("rst");
        RESET_n = 1'b1;
        @(negedge CLK);
        chk_idle_outputs("post_rst");
        run_dma(8'h02, 1'b0, -1, last_rd);
        chk("p02_last_rd", 32'(last_rd), 32'h02FF);
        run_dma(8'h02, 1'b1, -1, last_rd);
        run_dma(8'h03, 1'b0, -1, last_rd);
        chk("p03_hold_dout", 32'(dma_data_out), 32'h5A);
        run_dma(8'hFF, 1'b1, -1, last_rd);
        chk("pff_last_rd", 32'(last_rd), 32'hFFFF);
        cpu_addr = 16'h4014; cpu_rw_n = 1'b1; cpu_data_out = 8'h02;
        @(negedge CLK);
        cpu_addr = 16'h4015; cpu_rw_n = 1'b0;
        @(negedge CLK);
        cpu_addr = 16'h0000; cpu_rw_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("notrig_en", 32'(cpu_enable), 32'd1);
            chk("notrig_req", 32'(dma_bus_req), 32'd0);
            @(negedge CLK);
        end
        run_dma(8'h05, 1'b0, 8'h40, last_rd);
        @(negedge CLK);
        chk_idle_outputs("after_abort");
        run_dma(8'h06, 1'b0, -1, last_rd);
        chk("p06_last_rd", 32'(last_rd), 32'h06FF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
